// File: rtl/alu_muldiv_seq.sv
// Sequential multiply/divide unit: shift-add multiply and restoring division on
// operand magnitudes, STEP bits per cycle, with a sign fix-up cycle and a fast path.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating STEP product/quotient bits per cycle
// FIX   | sign correction and result select (also fast-path result)
// DONE  | result held until the consumer accepts it
module alu_muldiv_seq #(
  parameter int XLEN = 32,
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_opt,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  localparam int NCYC  = XLEN / STEP;
  localparam int CNT_W = $clog2(NCYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULH  = 4'd1;
  localparam logic [3:0] OP_MULHU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_REM   = 4'd5;
  localparam logic [3:0] OP_REMU  = 4'd6;

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        opt_q;
  logic              sign_a;
  logic              sign_b;
  logic              fast;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   fast_res;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   rem;

  // request decode: signs, magnitudes, fast-path detection
  logic            in_mul;
  logic            in_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            in_fast;
  logic [XLEN-1:0] in_fast_res;
  logic            b_zero;
  logic            ovf;

  always_comb begin
    in_mul    = (req_opt == OP_MUL) || (req_opt == OP_MULH) || (req_opt == OP_MULHU);
    in_signed = (req_opt == OP_MULH) || (req_opt == OP_DIV) || (req_opt == OP_REM);
    a_neg     = in_signed & req_a[XLEN-1];
    b_neg     = in_signed & req_b[XLEN-1];
    abs_a     = a_neg ? -req_a : req_a;
    abs_b     = b_neg ? -req_b : req_b;
    b_zero    = (req_b == '0);
    ovf       = (req_a == MIN_VAL) && (req_b == '1);
  end

  always_comb begin
    in_fast     = 1'b0;
    in_fast_res = '0;
    case (req_opt)
      OP_MUL, OP_MULH, OP_MULHU: in_fast = 1'b0;
      OP_DIV: begin
        if (b_zero) begin
          in_fast     = 1'b1;
          in_fast_res = '1;
        end else if (ovf) begin
          in_fast     = 1'b1;
          in_fast_res = MIN_VAL;
        end
      end
      OP_DIVU: begin
        in_fast     = b_zero;
        in_fast_res = '1;
      end
      OP_REM: begin
        if (b_zero) begin
          in_fast     = 1'b1;
          in_fast_res = req_a;
        end else if (ovf) begin
          in_fast     = 1'b1;
          in_fast_res = '0;
        end
      end
      OP_REMU: begin
        in_fast     = b_zero;
        in_fast_res = req_a;
      end
      default: begin
        in_fast     = 1'b1;
        in_fast_res = '0;
      end
    endcase
  end

  // one CALC step; the divide path walks the dividend out of acc[XLEN-1:0]
  logic                 op_mul;
  logic [XLEN+STEP-1:0] mul_hi;
  logic [2*XLEN-1:0]    acc_mul;
  logic [XLEN-1:0]      q_nxt;
  logic [XLEN-1:0]      r_nxt;
  logic [XLEN:0]        part;

  always_comb begin
    op_mul  = (opt_q == OP_MUL) || (opt_q == OP_MULH) || (opt_q == OP_MULHU);
    mul_hi  = {{STEP{1'b0}}, acc[2*XLEN-1:XLEN]}
            + ({{STEP{1'b0}}, opnd} * {{XLEN{1'b0}}, acc[STEP-1:0]});
    acc_mul = {mul_hi, acc[XLEN-1:STEP]};
    q_nxt   = acc[XLEN-1:0];
    r_nxt   = rem;
    part    = '0;
    for (int i = 0; i < STEP; i++) begin
      part  = {r_nxt, q_nxt[XLEN-1]};
      q_nxt = {q_nxt[XLEN-2:0], 1'b0};
      if (part >= {1'b0, opnd}) begin
        part     = part - {1'b0, opnd};
        q_nxt[0] = 1'b1;
      end
      r_nxt = part[XLEN-1:0];
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rmd;
  logic [XLEN-1:0]   fix_res;

  always_comb begin
    prod = (sign_a ^ sign_b) ? -acc : acc;
    quo  = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rmd  = sign_a ? -rem : rem;
    case (opt_q)
      OP_MUL:            fix_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:   fix_res = quo;
      OP_REM, OP_REMU:   fix_res = rmd;
      default:           fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opt_q    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      fast     <= 1'b0;
      opnd     <= '0;
      fast_res <= '0;
      acc      <= '0;
      rem      <= '0;
      rsp_data <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            opt_q    <= req_opt;
            sign_a   <= a_neg;
            sign_b   <= b_neg;
            fast     <= in_fast;
            fast_res <= in_fast_res;
            opnd     <= in_mul ? abs_a : abs_b;
            acc      <= {{XLEN{1'b0}}, (in_mul ? abs_b : abs_a)};
            rem      <= '0;
            cnt      <= '0;
            state    <= in_fast ? FIX : CALC;
          end
        end
        CALC: begin
          if (op_mul) begin
            acc <= acc_mul;
          end else begin
            acc <= {{XLEN{1'b0}}, q_nxt};
            rem <= r_nxt;
          end
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          rsp_data <= fast ? fast_res : fix_res;
          state    <= DONE;
        end
        default: begin
          if (rsp_ready) state <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == DONE);

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: directed corners, handshake/flush/reset behaviour and
// randomized operations against an arithmetic reference, on STEP=1 and STEP=4 instances.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_opt;
  logic [31:0] req_a;
  logic [31:0] req_b;

  logic        valid_1, ready_1, rsp_valid_1, rsp_ready_1, busy_1;
  logic [31:0] rsp_data_1;
  logic        valid_4, ready_4, rsp_valid_4, rsp_ready_4, busy_4;
  logic [31:0] rsp_data_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.XLEN(32), .STEP(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid_1), .req_ready(ready_1), .req_opt(req_opt),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_data(rsp_data_1),
    .busy(busy_1)
  );

  alu_muldiv_seq #(.XLEN(32), .STEP(4)) dut_4 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(valid_4), .req_ready(ready_4), .req_opt(req_opt),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_data(rsp_data_4),
    .busy(busy_4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic get_rv(input int w);
    return (w == 4) ? rsp_valid_4 : rsp_valid_1;
  endfunction
  function automatic logic get_rdy(input int w);
    return (w == 4) ? ready_4 : ready_1;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 4) ? busy_4 : busy_1;
  endfunction
  function automatic logic [31:0] get_data(input int w);
    return (w == 4) ? rsp_data_4 : rsp_data_1;
  endfunction

  task automatic set_valid(input int w, input logic v);
    if (w == 4) valid_4 = v; else valid_1 = v;
  endtask
  task automatic set_rsp_ready(input int w, input logic v);
    if (w == 4) rsp_ready_4 = v; else rsp_ready_1 = v;
  endtask

  function automatic int calc_lat(input int w);
    return (w == 4) ? 9 : 33;
  endfunction

  // reference: plain 64-bit / integer arithmetic with the fixed corner results
  function automatic logic [31:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    longint      sx;
    longint      sy;
    int          ia;
    int          ib;
    logic [31:0] r;
    ia = int'(a);
    ib = int'(b);
    sx = longint'(ia);
    sy = longint'(ib);
    r  = '0;
    case (o)
      4'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
      4'd1: begin p = sx * sy; r = p[63:32]; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      4'd3: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = 32'(ia / ib);
      end
      4'd4: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd5: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = 32'(ia % ib);
      end
      4'd6: r = (b == 0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit ref_fast(input logic [3:0] o, input logic [31:0] a,
                                  input logic [31:0] b);
    if (o >= 4'd7) return 1'b1;
    if (o >= 4'd3 && b == 0) return 1'b1;
    if ((o == 4'd3 || o == 4'd5) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
    return 1'b0;
  endfunction

  // issue one request at a negedge in IDLE; lat = edge index after which rsp_valid is seen
  task automatic do_op(input int w, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int hold,
                       output logic [31:0] d, output int lat);
    logic bad_rdy;
    req_opt = o;
    req_a   = a;
    req_b   = b;
    set_valid(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(w, 1'b0);
    req_a   = $urandom;
    req_b   = $urandom;
    req_opt = 4'($urandom_range(0, 15));
    lat     = 0;
    bad_rdy = 1'b0;
    while (!get_rv(w) && lat < 100) begin
      if (get_rdy(w) || !get_busy(w)) bad_rdy = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("ready_low_while_busy", bad_rdy, 0);
    chk("rsp_valid_seen", get_rv(w), 1);
    d = get_data(w);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", get_rv(w), 1);
      chk("hold_data", get_data(w), d);
      chk("hold_req_ready", get_rdy(w), 0);
    end
    set_rsp_ready(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_rsp_ready(w, 1'b0);
    chk("accept_valid_low", get_rv(w), 0);
    chk("accept_req_ready", get_rdy(w), 1);
    chk("accept_keep_data", get_data(w), d);
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [3:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        dir[$];
  logic [31:0] d;
  int          lat;
  logic        seen;
  logic [3:0]  ro;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    req_opt = '0; req_a = '0; req_b = '0;
    valid_1 = 1'b0; rsp_ready_1 = 1'b0;
    valid_4 = 1'b0; rsp_ready_4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", ready_1, 1);
    chk("reset_rsp_valid", rsp_valid_1, 0);
    chk("reset_rsp_data", rsp_data_1, 0);
    chk("reset_busy", busy_1, 0);
    chk("reset_req_ready_s4", ready_4, 1);
    rst_n = 1'b1;
    @(negedge clk);

    dir.push_back('{4'd0, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFCF, 33});
    dir.push_back('{4'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    dir.push_back('{4'd1, 32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 33});
    dir.push_back('{4'd1, 32'hFFFF_FFF9,  32'd3,         32'hFFFF_FFFF, 33});
    dir.push_back('{4'd5, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
    dir.push_back('{4'd3, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
    dir.push_back('{4'd4, 32'd100,        32'd7,         32'd14,        33});
    dir.push_back('{4'd6, 32'd100,        32'd7,         32'd2,         33});
    dir.push_back('{4'd4, 32'd100,        32'd0,         32'hFFFF_FFFF, 1});
    dir.push_back('{4'd5, 32'd5,          32'd0,         32'd5,         1});
    dir.push_back('{4'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    dir.push_back('{4'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    dir.push_back('{4'd9, 32'd123,        32'd45,        32'd0,         1});
    foreach (dir[i]) begin
      do_op(1, dir[i].o, dir[i].a, dir[i].b, 0, d, lat);
      chk($sformatf("dir%0d_data", i), d, dir[i].exp);
      chk($sformatf("dir%0d_lat", i), lat, dir[i].lat);
    end

    do_op(1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, d, lat);
    chk("hold_case_data", d, 32'hFFFF_FFFE);

    do_op(4, 4'd4, 32'hFFFF_FFFF, 32'd3, 0, d, lat);
    chk("s4_divu_data", d, 32'h5555_5555);
    chk("s4_divu_lat", lat, 9);

    // flush mid-CALC: back to IDLE next edge, no response ever
    req_opt = 4'd3; req_a = 32'd1000; req_b = 32'd7; valid_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_1 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_req_ready", ready_1, 1);
    chk("flush_busy", busy_1, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid_1) seen = 1'b1;
    end
    chk("flush_no_rsp", seen, 0);

    // flush beats a simultaneous request
    req_opt = 4'd0; req_a = 32'd3; req_b = 32'd4;
    flush = 1'b1; valid_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; valid_1 = 1'b0;
    chk("flush_vs_req_idle", busy_1, 0);

    // flush in DONE drops the held response
    req_opt = 4'd4; req_a = 32'd9; req_b = 32'd0; valid_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("fast_done_valid", rsp_valid_1, 1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_valid", rsp_valid_1, 0);
    chk("flush_done_ready", ready_1, 1);

    // async reset mid-CALC
    req_opt = 4'd0; req_a = 32'd11; req_b = 32'd13; valid_1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_1 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", ready_1, 1);
    chk("midrst_busy", busy_1, 0);
    chk("midrst_rsp_valid", rsp_valid_1, 0);
    chk("midrst_rsp_data", rsp_data_1, 0);
    chk("midrst_rsp_data_s4", rsp_data_4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 600; i++) begin
      ro = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      ra = pick_opnd();
      rb = pick_opnd();
      do_op(1, ro, ra, rb, $urandom_range(0, 1), d, lat);
      chk($sformatf("rand1 op%0d a=%h b=%h", ro, ra, rb), d, ref_op(ro, ra, rb));
      chk("rand1_lat", lat, ref_fast(ro, ra, rb) ? 1 : calc_lat(1));
    end
    for (int i = 0; i < 2500; i++) begin
      ro = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      ra = pick_opnd();
      rb = pick_opnd();
      do_op(4, ro, ra, rb, $urandom_range(0, 1), d, lat);
      chk($sformatf("rand4 op%0d a=%h b=%h", ro, ra, rb), d, ref_op(ro, ra, rb));
      chk("rand4_lat", lat, ref_fast(ro, ra, rb) ? 1 : calc_lat(4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
